// File: rtl/hazard_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package hazard_pkg;

  // Sequencing states: normal run, draining for a debug halt, parked
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ResultSrc encoding that identifies a load in EX
  localparam logic [2:0] RESULT_LOAD_ENC = 3'b001;

  // Bubbles needed to empty EX, MEM and WB
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  // Pick the youngest in-flight producer of a source register; x0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  // MEM result beats WB result because it is the younger write
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the RV32I five-stage pipeline: memory wait
// states with bus timeout, load-use interlock, and debug halt drain/park.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter logic [2:0]  RESULT_LOAD  = RESULT_LOAD_ENC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [2:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  input  logic       HaltReq,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       HaltAck,
  output logic       BusErr
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [1:0] DCNT_LAST   = 2'(DRAIN_CYCLES - 1);

  hz_state_e  state_q;
  logic [1:0] dcnt_q;
  logic [7:0] wcnt_q;
  logic [7:0] wcnt_d;
  logic       halt_ack_q;

  logic       mem_wait_s;
  logic       at_timeout_s;
  logic       mem_stall_s;
  logic       bus_err_s;
  logic       load_use_s;

  forward_unit u_forward_unit (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  // Memory wait tracking: once the wait reaches TIMEOUT the access is forced complete
  always_comb begin
    mem_wait_s   = MemReqM & ~MemReadyM;
    at_timeout_s = (wcnt_q == TIMEOUT_CNT);
    mem_stall_s  = mem_wait_s & ~at_timeout_s;
    bus_err_s    = mem_wait_s & at_timeout_s;
    if (mem_stall_s) begin
      wcnt_d = wcnt_q + 8'd1;
    end else begin
      wcnt_d = 8'd0;
    end
    load_use_s = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Wait-state counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt_q <= 8'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // Halt sequencer; memory stalls freeze it so drain bubbles are not lost
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RUN;
      dcnt_q     <= 2'd0;
      halt_ack_q <= 1'b0;
    end else if (mem_stall_s) begin
      state_q    <= state_q;
      dcnt_q     <= dcnt_q;
      halt_ack_q <= halt_ack_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (HaltReq) begin
            state_q <= ST_DRAIN;
            dcnt_q  <= 2'd0;
          end else begin
            state_q <= ST_RUN;
          end
          halt_ack_q <= 1'b0;
        end
        ST_DRAIN: begin
          if (!HaltReq) begin
            state_q    <= ST_RUN;
            dcnt_q     <= 2'd0;
            halt_ack_q <= 1'b0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q    <= ST_HALTED;
            dcnt_q     <= 2'd0;
            halt_ack_q <= 1'b1;
          end else begin
            dcnt_q     <= dcnt_q + 2'd1;
            halt_ack_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (!HaltReq) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
          end else begin
            halt_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          dcnt_q     <= 2'd0;
          halt_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall/flush decode: memory stall > taken branch > load-use / drain hold
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else begin
            FlushE = 1'b0;
          end
        end
        ST_DRAIN: begin
          // A branch resolving while draining redirects the PC and squashes D
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        ST_HALTED: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        default: begin
          FlushE = 1'b0;
        end
      endcase
    end
  end

  assign HaltAck = halt_ack_q;
  assign BusErr  = bus_err_s;

endmodule
